// File: rtl/ram_resp_pkg.sv
// Shared types and widths for the RAM1 MFC responder.
//   WORD_W     : data word width
//   WAIT_CNT_W : width of the wait-state counter (WAIT_STATES 0..15)
//   state_e    : responder FSM states
package ram_resp_pkg;
  localparam int WORD_W     = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ram_word_array.sv
// Synchronous single-port DEPTH x WORD_W word array.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_we           : write i_wdata to word i_idx on this edge
//   i_re           : load o_rdata from word i_idx on this edge
//   i_clr          : force o_rdata to zero on this edge (overrides i_re)
//   i_idx, i_wdata : word index, write data
//   o_rdata        : registered read data, holds until next i_re/i_clr/reset
// The storage itself is never reset; only the read register is.
module ram_word_array
  import ram_resp_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int INIT_ZERO = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic                     i_clr,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);
  logic [WORD_W-1:0] w_rd;
  logic [WORD_W-1:0] r_rdata;

  generate
    if (INIT_ZERO != 0) begin : g_init_zero
      // Declaration initialiser: zero at simulation start / FPGA power-up.
      logic [WORD_W-1:0] r_mem [DEPTH] = '{default: '0};
      always_ff @(posedge i_clk)
        if (i_we) r_mem[i_idx] <= i_wdata;
      assign w_rd = r_mem[i_idx];
    end else begin : g_init_none
      logic [WORD_W-1:0] r_mem [DEPTH];
      always_ff @(posedge i_clk)
        if (i_we) r_mem[i_idx] <= i_wdata;
      assign w_rd = r_mem[i_idx];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)   r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= w_rd;

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_mfc_responder.sv
// Memory-side responder for the processor RAM1 handshake, replacing the RAM1
// megafunction inside MemoryInterface.
//   Clock, Reset_L          : rising-edge clock, async active-low reset
//   RAM1_Address            : word address, low $clog2(DEPTH) bits index array
//   RAM1_Read_H_Write_L     : 1 = read, 0 = write
//   RAM1_Out_Enable         : level request strobe, held until MFC seen
//   RAM1_Data_In            : write data
//   RAM1_Data_Out           : last read data (valid while MFC=1)
//   RAM1_MFC                : memory function complete
//   RAM1_Err                : out-of-range flag (only with RAM_BOUNDS_CHECK_EN)
// Build option RAM_BOUNDS_CHECK_EN: addresses >= DEPTH suppress the access,
// zero Data_Out and raise Err with MFC. Undefined: address wraps modulo DEPTH.
// Flow: IDLE -capture-> BUSY (WAIT_STATES edges, then access) -> DONE -> IDLE.
module ram_mfc_responder
  import ram_resp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic [WORD_W-1:0] RAM1_Address,
  input  logic              RAM1_Read_H_Write_L,
  input  logic              RAM1_Out_Enable,
  input  logic [WORD_W-1:0] RAM1_Data_In,
  output logic [WORD_W-1:0] RAM1_Data_Out,
`ifdef RAM_BOUNDS_CHECK_EN
  output logic              RAM1_Err,
`endif
  output logic              RAM1_MFC
);
  localparam int AW = $clog2(DEPTH);

  state_e                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [AW-1:0]         r_idx;
  logic                  r_rd;
  logic [WORD_W-1:0]     r_wdata;
  logic                  r_mfc;
  logic                  w_capture;
  logic                  w_access;
  logic                  w_oob;

  assign w_capture = (r_state == IDLE) && RAM1_Out_Enable;
  // Access edge: counter exhausted and strobe still asserted (otherwise abort).
  assign w_access  = (r_state == BUSY) && RAM1_Out_Enable && (r_cnt == '0);

  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rd    <= 1'b0;
      r_wdata <= '0;
      r_mfc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (RAM1_Out_Enable) begin
            r_idx   <= RAM1_Address[AW-1:0];
            r_rd    <= RAM1_Read_H_Write_L;
            r_wdata <= RAM1_Data_In;
            r_cnt   <= WAIT_CNT_W'(WAIT_STATES);
            r_state <= BUSY;
          end
        BUSY:
          if (!RAM1_Out_Enable) r_state <= IDLE;
          else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_mfc   <= 1'b1;
            r_state <= DONE;
          end
        DONE:
          // Strobe must drop before a new request is taken.
          if (!RAM1_Out_Enable) begin
            r_mfc   <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end

`ifdef RAM_BOUNDS_CHECK_EN
  logic r_oob;
  logic r_err;

  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      r_oob <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_capture) r_oob <= |RAM1_Address[WORD_W-1:AW];
      if (w_access) r_err <= r_oob;
      else if (r_state == DONE && !RAM1_Out_Enable) r_err <= 1'b0;
    end

  assign w_oob    = r_oob;
  assign RAM1_Err = r_err;
`else
  // Upper address bits are deliberately ignored: the array wraps.
  logic w_unused_addr;
  assign w_unused_addr = ^RAM1_Address[WORD_W-1:AW];
  assign w_oob         = 1'b0;
`endif

  ram_word_array #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .i_clk   (Clock),
    .i_rst_n (Reset_L),
    .i_we    (w_access && !r_rd && !w_oob),
    .i_re    (w_access &&  r_rd && !w_oob),
    .i_clr   (w_access && w_oob),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (RAM1_Data_Out)
  );

  assign RAM1_MFC = r_mfc;
endmodule
